// File: rtl/multicycle_ctrl_if.sv
// Purpose: handshake/strobe bundle between the multicycle RV32I control FSM
//          and the datapath.
// Signals:
//   instruction_opcode  IR[6:0] seen by the controller
//   memory_ready        memory completes the current access this cycle
//   stall               hold the FSM in DECODE
//   pc_write_cond .. reg_write   datapath strobes/mux selects
//   trap, trap_cause    trap pulse and latched cause
//   instr_retired       one-cycle retire pulse
//   state_o             current FSM state (debug)
// Modports: master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [6:0] instruction_opcode;
  logic       memory_ready;
  logic       stall;
  logic       pc_write_cond;
  logic       pc_write;
  logic       lorD;
  logic       memory_read;
  logic       memory_write;
  logic       memory_to_reg;
  logic       ir_write;
  logic       pc_source;
  logic [1:0] aluop;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       reg_write;
  logic       trap;
  logic [1:0] trap_cause;
  logic       instr_retired;
  logic [2:0] state_o;

  modport master (
    input  instruction_opcode, memory_ready, stall,
    output pc_write_cond, pc_write, lorD, memory_read, memory_write,
           memory_to_reg, ir_write, pc_source, aluop, alu_src_a, alu_src_b,
           reg_write, trap, trap_cause, instr_retired, state_o
  );

  modport slave (
    output instruction_opcode, memory_ready, stall,
    input  pc_write_cond, pc_write, lorD, memory_read, memory_write,
           memory_to_reg, ir_write, pc_source, aluop, alu_src_a, alu_src_b,
           reg_write, trap, trap_cause, instr_retired, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Purpose: multicycle RV32I control FSM. Sequences FETCH/DECODE/EXECUTE/
//          MEMORY/WRITEBACK/TRAP, drives the datapath strobes combinationally
//          from state/opcode/memory_ready, handles memory wait with a bus
//          timeout, illegal and SYSTEM opcode traps, a decode stall and an
//          instruction-retired pulse.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low; all outputs read 0 while low
//   bus    multicycle_ctrl_if.master (opcode/ready/stall in, strobes out)
// Parameters:
//   MEM_WAIT_EN    1: wait for memory_ready, 0: memory is always ready
//   TIMEOUT_WIDTH  wait-counter width; timeout at counter == all-ones
//   ILLEGAL_TRAP   1: unknown opcode traps, 0: unknown opcode retires as NOP
module multicycle_ctrl #(
  parameter int MEM_WAIT_EN   = 1,
  parameter int TIMEOUT_WIDTH = 4,
  parameter int ILLEGAL_TRAP  = 1
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [TIMEOUT_WIDTH-1:0] WAIT_MAX = '1;
  localparam logic [TIMEOUT_WIDTH-1:0] WAIT_ONE = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   r_state;
  logic [TIMEOUT_WIDTH-1:0] r_wait;
  logic [1:0]               r_cause;

  state_t     w_next;
  logic [1:0] w_cause_next;
  logic [6:0] w_op;
  logic       w_ready, w_waiting, w_timeout, w_known, w_to_mem, w_retire;
  logic       w_pc_write_cond, w_pc_write, w_lorD, w_memory_read, w_memory_write;
  logic       w_memory_to_reg, w_ir_write, w_pc_source, w_reg_write, w_trap;
  logic [1:0] w_aluop, w_alu_src_a, w_alu_src_b;

  assign w_op    = bus.instruction_opcode;
  assign w_ready = (MEM_WAIT_EN == 0) || bus.memory_ready;

  // Only FETCH and the LOAD/STORE MEMORY cycles actually wait on memory.
  assign w_waiting = (MEM_WAIT_EN != 0) &&
                     ((r_state == S_FETCH) ||
                      ((r_state == S_MEMORY) && ((w_op == OP_LOAD) || (w_op == OP_STORE))));
  // A ready on the limit cycle takes precedence: timeout needs ready low.
  assign w_timeout = w_waiting && !bus.memory_ready && (r_wait == WAIT_MAX);

  // Opcode classification: w_to_mem marks opcodes that continue to MEMORY.
  always_comb begin
    w_known  = 1'b1;
    w_to_mem = 1'b0;
    case (w_op)
      OP_R, OP_I, OP_AUIPC, OP_LUI, OP_JAL, OP_JALR, OP_LOAD, OP_STORE: w_to_mem = 1'b1;
      OP_BRANCH, OP_FENCE, OP_SYSTEM: ;
      default: w_known = 1'b0;
    endcase
  end

  // Next state, trap cause and retire decision.
  always_comb begin
    w_next       = r_state;
    w_cause_next = r_cause;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_ready) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next       = S_TRAP;
          w_cause_next = 2'b10;
        end
      end
      S_DECODE: begin
        if (!bus.stall) begin
          if (w_op == OP_SYSTEM) begin
            w_next       = S_TRAP;
            w_cause_next = 2'b11;
          end else if (!w_known && (ILLEGAL_TRAP != 0)) begin
            w_next       = S_TRAP;
            w_cause_next = 2'b01;
          end else begin
            w_next = S_EXECUTE;
          end
        end
      end
      S_EXECUTE: begin
        if (w_to_mem) begin
          w_next = S_MEMORY;
        end else begin
          // BRANCH, FENCE and unknown-as-NOP finish here.
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_MEMORY: begin
        case (w_op)
          OP_LOAD: begin
            if (w_ready) begin
              w_next = S_WRITEBACK;
            end else if (w_timeout) begin
              w_next       = S_TRAP;
              w_cause_next = 2'b10;
            end
          end
          OP_STORE: begin
            if (w_ready) begin
              w_next   = S_FETCH;
              w_retire = 1'b1;
            end else if (w_timeout) begin
              w_next       = S_TRAP;
              w_cause_next = 2'b10;
            end
          end
          default: begin
            w_next   = S_FETCH;
            w_retire = w_to_mem;
          end
        endcase
      end
      S_WRITEBACK: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // State, wait counter and trap cause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause_next;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (w_waiting && !bus.memory_ready && (r_wait != WAIT_MAX)) begin
        r_wait <= r_wait + WAIT_ONE;
      end
    end
  end

  // Datapath strobes; gated by reset so an access drops the instant reset falls.
  always_comb begin
    w_pc_write_cond = 1'b0;
    w_pc_write      = 1'b0;
    w_lorD          = 1'b0;
    w_memory_read   = 1'b0;
    w_memory_write  = 1'b0;
    w_memory_to_reg = 1'b0;
    w_ir_write      = 1'b0;
    w_pc_source     = 1'b0;
    w_aluop         = 2'b00;
    w_alu_src_a     = 2'b00;
    w_alu_src_b     = 2'b00;
    w_reg_write     = 1'b0;
    w_trap          = 1'b0;
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          w_memory_read = 1'b1;
          w_alu_src_b   = 2'b01;
          w_ir_write    = w_ready;
          w_pc_write    = w_ready;
        end
        S_DECODE: begin
          w_alu_src_b = 2'b10;
          if (w_op == OP_JALR) w_alu_src_a = 2'b01;
        end
        S_EXECUTE: begin
          case (w_op)
            OP_R: begin
              w_alu_src_a = 2'b01;
              w_aluop     = 2'b10;
            end
            OP_I: begin
              w_alu_src_a = 2'b01;
              w_alu_src_b = 2'b10;
              w_aluop     = 2'b10;
            end
            OP_AUIPC: w_alu_src_b = 2'b10;
            OP_LUI: begin
              w_alu_src_a = 2'b10;
              w_alu_src_b = 2'b10;
            end
            OP_JAL, OP_JALR: begin
              w_alu_src_b = 2'b01;
              w_pc_write  = 1'b1;
              w_pc_source = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
              w_alu_src_a = 2'b01;
              w_alu_src_b = 2'b10;
            end
            OP_BRANCH: begin
              w_alu_src_a     = 2'b01;
              w_aluop         = 2'b01;
              w_pc_write_cond = 1'b1;
              w_pc_source     = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEMORY: begin
          case (w_op)
            OP_LOAD: begin
              w_memory_read = 1'b1;
              w_lorD        = 1'b1;
            end
            OP_STORE: begin
              w_memory_write = 1'b1;
              w_lorD         = 1'b1;
            end
            default: w_reg_write = w_to_mem;
          endcase
        end
        S_WRITEBACK: begin
          w_reg_write     = 1'b1;
          w_memory_to_reg = 1'b1;
        end
        S_TRAP: w_trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.pc_write_cond = w_pc_write_cond;
  assign bus.pc_write      = w_pc_write;
  assign bus.lorD          = w_lorD;
  assign bus.memory_read   = w_memory_read;
  assign bus.memory_write  = w_memory_write;
  assign bus.memory_to_reg = w_memory_to_reg;
  assign bus.ir_write      = w_ir_write;
  assign bus.pc_source     = w_pc_source;
  assign bus.aluop         = w_aluop;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.reg_write     = w_reg_write;
  assign bus.trap          = w_trap;
  assign bus.trap_cause    = r_cause;
  assign bus.instr_retired = reset && w_retire;
  assign bus.state_o       = r_state;

endmodule
